// File: rtl/xy_switch_arbiter_if.sv
// Request/grant and crossbar-select signals between the router ports
// and the XY switch arbiter.
interface xy_switch_arbiter_if #(
    parameter int NPORT     = 5,
    parameter int FLIT_SIZE = 16
);
    localparam int METADEFLIT = FLIT_SIZE / 2;

    logic [METADEFLIT-1:0]           address;
    logic [NPORT-1:0]                h;
    logic [NPORT-1:0][FLIT_SIZE-1:0] data;
    logic [NPORT-1:0]                sender;
    logic [NPORT-1:0]                ack_h;
    logic [NPORT-1:0]                free;
    logic [NPORT-1:0][2:0]           mux_in;
    logic [NPORT-1:0][2:0]           mux_out;

    modport master (
        output address, h, data, sender,
        input  ack_h, free, mux_in, mux_out
    );

    modport slave (
        input  address, h, data, sender,
        output ack_h, free, mux_in, mux_out
    );
endinterface

// File: rtl/xy_switch_arbiter.sv
// Round-robin header arbiter with XY routing for a 5-port mesh router;
// allocates crossbar outputs and frees them when a packet stops streaming.
module xy_switch_arbiter #(
    parameter int NPORT     = 5,
    parameter int FLIT_SIZE = 16
) (
    input logic                clock,
    input logic                reset,
    xy_switch_arbiter_if.slave bus
);
    localparam int METADEFLIT = FLIT_SIZE / 2;
    localparam int QUARTOFLIT = FLIT_SIZE / 4;

    localparam logic [2:0] EAST  = 3'd0;
    localparam logic [2:0] WEST  = 3'd1;
    localparam logic [2:0] NORTH = 3'd2;
    localparam logic [2:0] SOUTH = 3'd3;
    localparam logic [2:0] LOCAL = 3'd4;

    typedef enum logic [1:0] {IDLE, ARB, ROUTE, GRANT} state_e;

    state_e                state_q, state_d;
    logic [2:0]            ptr_q, ptr_d;
    logic [2:0]            dir_q, dir_d;
    logic [NPORT-1:0]      ack_q, ack_d;
    logic [NPORT-1:0]      free_q, free_d;
    logic [NPORT-1:0]      conn_q, conn_d;
    logic [NPORT-1:0]      sender_q, sender_d;
    logic [NPORT-1:0][2:0] mux_in_q, mux_in_d;
    logic [NPORT-1:0][2:0] mux_out_q, mux_out_d;

    logic [FLIT_SIZE-1:0]  flit;
    logic [QUARTOFLIT-1:0] tx, ty, lx, ly;
    logic [2:0]            route;
    logic [2:0]            rr_sel;
    logic [2:0]            rr_cand;
    logic                  rr_hit;

    assign flit = bus.data[ptr_q];
    assign tx   = flit[METADEFLIT-1:QUARTOFLIT];
    assign ty   = flit[QUARTOFLIT-1:0];
    assign lx   = bus.address[METADEFLIT-1:QUARTOFLIT];
    assign ly   = bus.address[QUARTOFLIT-1:0];

    // X is resolved before Y
    always_comb begin
        route = SOUTH;
        if (tx == lx && ty == ly) route = LOCAL;
        else if (lx < tx)         route = EAST;
        else if (lx > tx)         route = WEST;
        else if (ly < ty)         route = NORTH;
    end

    always_comb begin
        rr_hit  = 1'b0;
        rr_sel  = ptr_q;
        rr_cand = ptr_q;
        for (int k = 1; k <= NPORT; k++) begin
            rr_cand = 3'((int'(ptr_q) + k) % NPORT);
            if (!rr_hit && bus.h[rr_cand]) begin
                rr_hit = 1'b1;
                rr_sel = rr_cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        dir_d     = dir_q;
        ack_d     = '0;
        free_d    = free_q;
        conn_d    = conn_q;
        mux_in_d  = mux_in_q;
        mux_out_d = mux_out_q;
        sender_d  = bus.sender;

        unique case (state_q)
            IDLE: begin
                if (|bus.h) state_d = ARB;
            end
            ARB: begin
                if (rr_hit) begin
                    ptr_d   = rr_sel;
                    state_d = ROUTE;
                end else begin
                    state_d = IDLE;
                end
            end
            ROUTE: begin
                dir_d   = route;
                state_d = GRANT;
            end
            GRANT: begin
                if (free_q[dir_q] && bus.h[ptr_q]) begin
                    ack_d[ptr_q]     = 1'b1;
                    free_d[dir_q]    = 1'b0;
                    mux_in_d[ptr_q]  = dir_q;
                    mux_out_d[dir_q] = ptr_q;
                    conn_d[ptr_q]    = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // grant looked at pre-release free, so a same-cycle release still lands
        for (int i = 0; i < NPORT; i++) begin
            if (conn_q[i] && sender_q[i] && !bus.sender[i]) begin
                free_d[mux_in_q[i]] = 1'b1;
                conn_d[i]           = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= LOCAL;
            dir_q     <= EAST;
            ack_q     <= '0;
            free_q    <= '1;
            conn_q    <= '0;
            sender_q  <= '0;
            mux_in_q  <= '0;
            mux_out_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            dir_q     <= dir_d;
            ack_q     <= ack_d;
            free_q    <= free_d;
            conn_q    <= conn_d;
            sender_q  <= sender_d;
            mux_in_q  <= mux_in_d;
            mux_out_q <= mux_out_d;
        end
    end

    assign bus.ack_h   = ack_q;
    assign bus.free    = free_q;
    assign bus.mux_in  = mux_in_q;
    assign bus.mux_out = mux_out_q;
endmodule

// File: tb/tb_xy_switch_arbiter.sv
// Directed bench for xy_switch_arbiter: latency, XY routing, round-robin,
// release handling and mid-grant reset.
module tb_xy_switch_arbiter;
    logic clock;
    logic reset;
    int   compared;
    int   mismatched;
    logic got;
    logic [4:0] acc;

    xy_switch_arbiter_if #(.NPORT(5), .FLIT_SIZE(16)) bus ();

    xy_switch_arbiter #(.NPORT(5), .FLIT_SIZE(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clear_inputs();
        bus.h      = '0;
        bus.sender = '0;
        bus.data   = '0;
    endtask

    // one request from LOCAL to target, check the chosen output, then release it
    task automatic route_case(input string tag, input logic [15:0] tgt,
                              input logic [2:0] exp_dir, input logic [4:0] exp_free);
        bus.data[4]   = tgt;
        bus.h[4]      = 1'b1;
        bus.sender[4] = 1'b1;
        tick(4);
        chk({tag, "_ack"}, 32'(bus.ack_h), 32'h10);
        chk({tag, "_mux_in"}, 32'(bus.mux_in[4]), 32'(exp_dir));
        chk({tag, "_mux_out"}, 32'(bus.mux_out[exp_dir]), 32'd4);
        bus.h[4]      = 1'b0;
        bus.sender[4] = 1'b0;
        tick(1);
        chk({tag, "_released"}, 32'(bus.free), 32'(exp_free));
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        reset       = 1'b1;
        bus.address = 8'h11;
        clear_inputs();

        tick(1);
        chk("rst_ack", 32'(bus.ack_h), 32'h0);
        chk("rst_free", 32'(bus.free), 32'h1f);
        chk("rst_mux_in", 32'(bus.mux_in), 32'h0);
        chk("rst_mux_out", 32'(bus.mux_out), 32'h0);
        reset = 1'b0;
        tick(1);

        // WEST -> LOCAL, exact latency
        bus.data[1]   = 16'h0011;
        bus.h[1]      = 1'b1;
        bus.sender[1] = 1'b1;
        tick(3);
        chk("w_early", 32'(bus.ack_h), 32'h0);
        tick(1);
        chk("w_ack", 32'(bus.ack_h), 32'h02);
        chk("w_mux_in", 32'(bus.mux_in[1]), 32'd4);
        chk("w_mux_out", 32'(bus.mux_out[4]), 32'd1);
        chk("w_free", 32'(bus.free), 32'h0f);
        bus.h[1] = 1'b0;
        tick(1);
        chk("w_pulse", 32'(bus.ack_h), 32'h0);

        route_case("r_east", 16'h0021, 3'd0, 5'h0f);
        route_case("r_west", 16'h0001, 3'd1, 5'h0f);
        route_case("r_north", 16'h0012, 3'd2, 5'h0f);
        route_case("r_south", 16'h0010, 3'd3, 5'h0f);

        // EAST blocked on LOCAL until WEST stops streaming
        bus.data[0]   = 16'h0011;
        bus.h[0]      = 1'b1;
        bus.sender[0] = 1'b1;
        acc = '0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            acc = acc | bus.ack_h;
        end
        chk("blk_no_ack", 32'(acc), 32'h0);
        bus.sender[1] = 1'b0;
        tick(1);
        chk("blk_release", 32'(bus.free), 32'h1f);
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            tick(1);
            if (bus.ack_h[0]) got = 1'b1;
        end
        chk("blk_ack_seen", 32'(got), 32'h1);
        chk("blk_ack", 32'(bus.ack_h), 32'h01);
        chk("blk_mux_out", 32'(bus.mux_out[4]), 32'd0);
        chk("blk_mux_in", 32'(bus.mux_in[0]), 32'd4);
        chk("blk_free", 32'(bus.free), 32'h0f);
        bus.h[0]      = 1'b0;
        bus.sender[0] = 1'b0;
        tick(2);
        chk("blk_freed", 32'(bus.free), 32'h1f);

        // round-robin: EAST then NORTH one round later
        reset = 1'b1;
        clear_inputs();
        tick(1);
        reset = 1'b0;
        tick(1);
        bus.data[0]   = 16'h0021;
        bus.data[2]   = 16'h0010;
        bus.h         = 5'b00101;
        bus.sender    = 5'b00101;
        tick(3);
        chk("rr_early", 32'(bus.ack_h), 32'h0);
        tick(1);
        chk("rr_east", 32'(bus.ack_h), 32'h01);
        chk("rr_east_free", 32'(bus.free), 32'h1e);
        bus.h[0] = 1'b0;
        tick(3);
        chk("rr_gap", 32'(bus.ack_h), 32'h0);
        tick(1);
        chk("rr_north", 32'(bus.ack_h), 32'h04);
        chk("rr_n_mux_in", 32'(bus.mux_in[2]), 32'd3);
        chk("rr_n_mux_out", 32'(bus.mux_out[3]), 32'd2);
        chk("rr_n_free", 32'(bus.free), 32'h16);
        bus.h[2] = 1'b0;

        // reset in the GRANT cycle
        reset = 1'b1;
        clear_inputs();
        tick(1);
        reset = 1'b0;
        tick(1);
        bus.data[1]   = 16'h0011;
        bus.h[1]      = 1'b1;
        bus.sender[1] = 1'b1;
        tick(3);
        reset = 1'b1;
        #1;
        chk("mg_ack", 32'(bus.ack_h), 32'h0);
        chk("mg_free", 32'(bus.free), 32'h1f);
        chk("mg_mux", 32'({bus.mux_in, bus.mux_out}), 32'h0);
        tick(1);
        chk("mg_hold_ack", 32'(bus.ack_h), 32'h0);
        chk("mg_hold_free", 32'(bus.free), 32'h1f);
        reset = 1'b0;
        tick(3);
        chk("mg_early", 32'(bus.ack_h), 32'h0);
        tick(1);
        chk("mg_regrant", 32'(bus.ack_h), 32'h02);
        chk("mg_mux_in", 32'(bus.mux_in[1]), 32'd4);
        chk("mg_mux_out", 32'(bus.mux_out[4]), 32'd1);
        bus.h[1] = 1'b0;
        tick(1);

        // request withdrawn before GRANT: no ack, nothing allocated
        bus.data[3]   = 16'h0012;
        bus.h[3]      = 1'b1;
        bus.sender[3] = 1'b1;
        tick(2);
        bus.h[3] = 1'b0;
        tick(2);
        chk("wd_ack", 32'(bus.ack_h), 32'h0);
        chk("wd_free", 32'(bus.free), 32'h0f);
        chk("wd_mux_in", 32'(bus.mux_in[3]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule

// File: doc/xy_switch_arbiter.md
XY_SWITCH_ARBITER -- requirements
Module: xy_switch_arbiter

Interface
REQ-001 The module SHALL have parameter NPORT, default 5, giving the number of router ports (EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4).
REQ-002 The module SHALL have parameter FLIT_SIZE, default 16, giving the flit width; METADEFLIT = FLIT_SIZE/2 and QUARTOFLIT = FLIT_SIZE/4.
REQ-003 The module SHALL have the following ports:
  clock     in   1                  single clock; all state updates on posedge
  reset     in   1                  asynchronous, active-high
  address   in   METADEFLIT         router XY address; X = upper QUARTOFLIT bits, Y = lower QUARTOFLIT bits
  h         in   NPORT              per-input header-pending request
  data      in   NPORT x FLIT_SIZE  per-input head flit; bits METADEFLIT-1:0 hold the target XY
  sender    in   NPORT              per-input "packet still streaming" flag
  ack_h     out  NPORT              one-cycle grant pulse to the selected input
  free      out  NPORT              per-output availability (1 = unallocated)
  mux_in    out  NPORT x 3          per input: index of the output it drives
  mux_out   out  NPORT x 3          per output: index of the input feeding it

Function
REQ-004 The FSM SHALL have states IDLE, ARB, ROUTE, GRANT.
REQ-005 IDLE SHALL go to ARB when any h bit is 1, and SHALL stay in IDLE otherwise.
REQ-006 ARB SHALL select port sel by round-robin, searching from (ptr+1) mod NPORT upward and wrapping; it SHALL set ptr <= sel and go to ROUTE.
REQ-007 If no h bit is set when ARB evaluates, ARB SHALL return to IDLE without updating ptr.
REQ-008 ROUTE SHALL register dir from data[sel] (tx/ty = target X/Y; lx/ly = local X/Y) by XY order:
  - LOCAL if tx==lx and ty==ly
  - else EAST if lx<tx
  - else WEST if lx>tx
  - else NORTH if ly<ty
  - else SOUTH.
REQ-009 The XY comparisons SHALL be unsigned on QUARTOFLIT-bit fields.
REQ-010 ROUTE SHALL always go to GRANT.
REQ-011 In GRANT with free[dir]=1, the block SHALL assert ack_h[sel]=1 for exactly that cycle.
REQ-012 On the posedge that ends a successful GRANT cycle, the block SHALL set free[dir]<=0, mux_in[sel]<=dir, mux_out[dir]<=sel and connected[sel]<=1.
REQ-013 In GRANT with free[dir]=0, the block SHALL assert no ack_h bit and SHALL leave the connection state unchanged; the request is retried later under round-robin.
REQ-014 GRANT SHALL always go to IDLE.
REQ-015 At most one ack_h bit SHALL be 1 in any cycle.
REQ-016 Grant latency SHALL be exactly 3 cycles: h sampled in IDLE at edge k gives ack_h high in the cycle following edge k+3, when the output is free and no other port wins arbitration.
REQ-017 Requesters hold h until they see ack_h; if h[sel] drops before GRANT, GRANT SHALL still evaluate free but SHALL issue no ack_h.
REQ-018 The block SHALL keep a registered copy sender_q.
REQ-019 A release SHALL occur for input i when connected[i]=1, sender_q[i]=1 and sender[i]=0.
REQ-020 On a release, at the next posedge the block SHALL set free[mux_in[i]]<=1 and connected[i]<=0; mux_in and mux_out keep their stale values.
REQ-021 Releases SHALL be processed every cycle, independently of FSM state, and multiple releases in one cycle SHALL all take effect.
REQ-022 A release and a GRANT to the same output in the same cycle: GRANT SHALL use the pre-release free value (sees busy, no ack), and the release SHALL take effect.
REQ-023 Output values 5..7 SHALL never be produced on mux_in or mux_out.

Reset
REQ-024 While reset=1, asynchronously, the block SHALL drive state=IDLE, ptr=LOCAL (first search starts at EAST), ack_h=0, free=all 1, mux_in=all 0, mux_out=all 0, connected=0 and sender_q=0.
REQ-025 Reset asserted mid-GRANT SHALL suppress ack_h in that same cycle and discard the pending allocation.
REQ-026 After reset deasserts, arbitration SHALL restart from IDLE on the next posedge.

Verification
REQ-027 With address=0x11, h[WEST]=1 and data[WEST][7:0]=0x11, the bench SHALL see ack_h=00010b (WEST) 3 cycles later, then mux_in[WEST]=4, mux_out[LOCAL]=1 and free[LOCAL]=0.
REQ-028 With address=0x11, the bench SHALL see target 0x21 from LOCAL route to EAST, target 0x01 route to WEST, target 0x12 route to NORTH and target 0x10 route to SOUTH.
REQ-029 After reset, with h[EAST] and h[NORTH] raised together for distinct outputs, the bench SHALL see EAST acked first and NORTH acked in the next arbitration round, 4 cycles later.
REQ-030 With LOCAL held by WEST and h[EAST] targeting 0x11, the bench SHALL see no ack_h[EAST] until sender[WEST] falls 1->0, then free[LOCAL]=1 and a later ack_h[EAST] with mux_out[LOCAL]=0.
REQ-031 With reset pulsed during the GRANT cycle, the bench SHALL see ack_h=0, free=11111b, all mux fields 0, and a fresh 3-cycle grant once h is re-presented.
